// File: rtl/cjb_io_pkg.sv
// Shared constants for the board input-conditioning stage (button + switches).
package cjb_io_pkg;

  localparam int   DB_CNT_DEFAULT = 500000;
  localparam logic PB_IDLE        = 1'b1;
  localparam logic SW_IDLE        = 1'b0;
  localparam int   NUM_SW         = 4;

  // Counter width max(1, clog2(db_cnt)); the counter only ever reaches db_cnt-1.
  function automatic int cnt_width(input int db_cnt);
    return (db_cnt <= 1) ? 1 : $clog2(db_cnt);
  endfunction

endpackage

// File: rtl/cjb_debounce_bit.sv
// One debounce channel: 2-FF synchroniser, hold counter and accepted state,
// with a one-cycle upd pulse in the cycle the accepted state changes.
module cjb_debounce_bit
  import cjb_io_pkg::*;
#(
  parameter int   DB_CNT  = DB_CNT_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic state,
  output logic upd
);

  localparam int           CW       = cnt_width(DB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync_a <= RST_VAL;
      sync_b <= RST_VAL;
      state  <= RST_VAL;
      cnt    <= '0;
      upd    <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      upd    <= 1'b0;
      // Any return to the accepted level restarts the hold window.
      if (sync_b == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= sync_b;
        cnt   <= '0;
        upd   <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cjb_io_debounce.sv
// Debounces the push-button and slide switches feeding the cjbRISC core and
// derives a button-press strobe and a switch-change strobe.
module cjb_io_debounce
  import cjb_io_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PB1_raw,
  input  logic [NUM_SW-1:0] SW_raw,
  output logic              PB1,
  output logic [NUM_SW-1:0] SW,
  output logic              PB1_press,
  output logic              SW_chg
);

  logic              pb_state;
  logic              pb_upd;
  logic [NUM_SW-1:0] sw_state;
  logic [NUM_SW-1:0] sw_upd;

  cjb_debounce_bit #(.DB_CNT(DB_CNT), .RST_VAL(PB_IDLE)) u_pb (
    .clk   (Clock),
    .rst_b (Reset),
    .raw   (PB1_raw),
    .state (pb_state),
    .upd   (pb_upd)
  );

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    cjb_debounce_bit #(.DB_CNT(DB_CNT), .RST_VAL(SW_IDLE)) u_sw (
      .clk   (Clock),
      .rst_b (Reset),
      .raw   (SW_raw[i]),
      .state (sw_state[i]),
      .upd   (sw_upd[i])
    );
  end

  // Both strobes are gates of flops that update on the same edge as the
  // levels, so they line up with the level change and carry no input path.
  assign PB1       = pb_state;
  assign SW        = sw_state;
  assign PB1_press = pb_upd & ~pb_state;
  assign SW_chg    = |sw_upd;

endmodule

// File: tb/tb_cjb_io_debounce.sv
// Directed bench for cjb_io_debounce with DB_CNT=8: table of held segments
// plus hand sequences for exact latency, bounce, stagger and reset corners.
module tb_cjb_io_debounce;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       pb_raw;
  logic [3:0] sw_raw;
  logic       pb;
  logic [3:0] sw;
  logic       press;
  logic       chg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cjb_io_debounce #(.DB_CNT(DB)) dut (
    .Clock     (clk),
    .Reset     (rst_b),
    .PB1_raw   (pb_raw),
    .SW_raw    (sw_raw),
    .PB1       (pb),
    .SW        (sw),
    .PB1_press (press),
    .SW_chg    (chg)
  );

  typedef struct {
    logic       rst;
    logic       pb;
    logic [3:0] sw;
    int         cycles;
    logic       exp_pb;
    logic [3:0] exp_sw;
    int         exp_press;
    int         exp_chg;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int np;
    int nc;
    int lvl_ok;
    int pulse_lvl[4];
    int pulse_len[4];
    logic [3:0] exp_sw;

    rst_b  = 1'b0;
    pb_raw = 1'b0;
    sw_raw = 4'hF;

    // Reset with inputs at their active levels: outputs pinned to idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pb", pb, 1'b1);
      chk("rst_sw", sw, 4'h0);
      chk("rst_press", press, 1'b0);
      chk("rst_chg", chg, 1'b0);
    end

    tbl[0] = '{1'b0, 1'b1, 4'h0,  3, 1'b1, 4'h0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 4'h5, 12, 1'b0, 4'h5, 1, 1};
    tbl[2] = '{1'b1, 1'b0, 4'h5, 12, 1'b0, 4'h5, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 4'hA, 12, 1'b1, 4'hA, 0, 1};
    tbl[4] = '{1'b1, 1'b0, 4'hF,  5, 1'b1, 4'hA, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 4'hA, 12, 1'b1, 4'hA, 0, 0};
    tbl[6] = '{1'b0, 1'b0, 4'hF,  2, 1'b1, 4'h0, 0, 0};
    tbl[7] = '{1'b1, 1'b1, 4'h0, 12, 1'b1, 4'h0, 0, 0};

    for (int v = 0; v < 8; v++) begin
      rst_b  = tbl[v].rst;
      pb_raw = tbl[v].pb;
      sw_raw = tbl[v].sw;
      np = 0;
      nc = 0;
      repeat (tbl[v].cycles) begin
        tick();
        np += int'(press);
        nc += int'(chg);
      end
      chk($sformatf("tbl%0d_pb", v), pb, tbl[v].exp_pb);
      chk($sformatf("tbl%0d_sw", v), sw, tbl[v].exp_sw);
      chk($sformatf("tbl%0d_npress", v), np, tbl[v].exp_press);
      chk($sformatf("tbl%0d_nchg", v), nc, tbl[v].exp_chg);
    end

    // Clean press: falls on the 10th edge counting the first sampling edge.
    pb_raw = 1'b0;
    repeat (9) tick();
    chk("press_pb_e9", pb, 1'b1);
    chk("press_str_e9", press, 1'b0);
    tick();
    chk("press_pb_e10", pb, 1'b0);
    chk("press_str_e10", press, 1'b1);
    tick();
    chk("press_pb_e11", pb, 1'b0);
    chk("press_str_e11", press, 1'b0);

    // Release: level returns after 10 edges, no strobe.
    pb_raw = 1'b1;
    np = 0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      np += int'(press);
      if (t == 9)  chk("rel_pb_e9", pb, 1'b0);
      if (t == 10) chk("rel_pb_e10", pb, 1'b1);
    end
    chk("rel_npress", np, 0);

    // Bounce: 3-cycle and 7-cycle low pulses are rejected, then a hold.
    pulse_lvl = '{0, 1, 0, 1};
    pulse_len = '{3, 3, 7, 3};
    np = 0;
    lvl_ok = 1;
    for (int p = 0; p < 4; p++) begin
      pb_raw = pulse_lvl[p][0];
      repeat (pulse_len[p]) begin
        tick();
        np += int'(press);
        if (pb !== 1'b1) lvl_ok = 0;
      end
    end
    pb_raw = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t <= 9) begin
        np += int'(press);
        if (pb !== 1'b1) lvl_ok = 0;
      end
      if (t == 10) begin
        chk("bnc_pb_e10", pb, 1'b0);
        chk("bnc_str_e10", press, 1'b1);
      end
      if (t == 11) chk("bnc_str_e11", press, 1'b0);
    end
    chk("bnc_level_held", lvl_ok, 1);
    chk("bnc_npress_early", np, 0);

    pb_raw = 1'b1;
    repeat (12) tick();
    chk("bnc_released", pb, 1'b1);

    // Switches: 0 -> 1010 in one go gives one strobe.
    sw_raw = 4'b1010;
    nc = 0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      nc += int'(chg);
      if (t == 9)  chk("sw_e9", sw, 4'h0);
      if (t == 10) begin
        chk("sw_e10", sw, 4'hA);
        chk("sw_chg_e10", chg, 1'b1);
      end
    end
    chk("sw_nchg", nc, 1);

    // Bit 3 drops, bit 0 rises two cycles later: two separate strobes.
    sw_raw = 4'b0010;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 2) sw_raw = 4'b0011;
      exp_sw = (t < 10) ? 4'hA : (t < 12) ? 4'h2 : 4'h3;
      chk($sformatf("stag_sw_t%0d", t), sw, exp_sw);
      chk($sformatf("stag_chg_t%0d", t), chg, ((t == 10) || (t == 12)) ? 1'b1 : 1'b0);
    end

    // Reset 5 cycles into a pending SW[2] rise; count restarts after release.
    sw_raw = 4'b0111;
    repeat (5) tick();
    chk("mid_pre_sw", sw, 4'h3);
    rst_b = 1'b0;
    tick();
    chk("mid_rst_sw", sw, 4'h0);
    chk("mid_rst_chg", chg, 1'b0);
    rst_b = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 9) chk("mid_sw_e9", sw, 4'h0);
      if (t == 10) begin
        chk("mid_sw_e10", sw, 4'h7);
        chk("mid_chg_e10", chg, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
